// File: rtl/sram_ctrl_pkg.sv
// Shared defaults and state encoding for the single-port SRAM access controller.
package sram_ctrl_pkg;
  localparam int DEF_SETS   = 512;
  localparam int DEF_LANE_W = 12;
  localparam int DEF_LANES  = 2;
  localparam int DEF_SET_W  = $clog2(DEF_SETS);
  localparam int DEF_DATA_W = DEF_LANE_W * DEF_LANES;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;
endpackage

// File: rtl/sram_resp_hold.sv
// One-entry read response skid: macro data is bypassed in the cycle after the
// read issue and captured into a hold register so it stays stable under stall.
module sram_resp_hold #(
  parameter int DATA_W = 24
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              issue,
  input  logic [DATA_W-1:0] rdata,
  input  logic              resp_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data
);
  logic              rd_pend;   // macro data is on rdata this cycle
  logic              held_vld;  // undelivered data sits in hold_q
  logic [DATA_W-1:0] hold_q;

  assign resp_valid = rd_pend | held_vld;
  assign resp_data  = rd_pend ? rdata : hold_q;

  // Track the in-flight read and whether its data still awaits the consumer.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_pend  <= 1'b0;
      held_vld <= 1'b0;
    end else begin
      rd_pend  <= issue;
      held_vld <= resp_valid & ~resp_ready;
    end
  end

  // Capture macro data the only cycle it is valid; later writes cannot disturb it.
  always_ff @(posedge clock) begin
    if (rd_pend) hold_q <= rdata;
  end
endmodule

// File: rtl/sram_sp_rw_ctrl.sv
// Single-port masked SRAM access controller: zero-fill sweep after reset, then
// write-priority merge of read/write request channels onto the RW0 port.
module sram_sp_rw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int SETS          = DEF_SETS,
  parameter int LANE_W        = DEF_LANE_W,
  parameter int LANES         = DEF_LANES,
  parameter int INIT_ON_RESET = 1,
  parameter int SET_W         = $clog2(SETS),
  parameter int DATA_W        = LANE_W * LANES
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              w_req_valid,
  output logic              w_req_ready,
  input  logic [SET_W-1:0]  w_req_set,
  input  logic [DATA_W-1:0] w_req_data,
  input  logic [LANES-1:0]  w_req_mask,
  input  logic              r_req_valid,
  output logic              r_req_ready,
  input  logic [SET_W-1:0]  r_req_set,
  output logic              r_resp_valid,
  input  logic              r_resp_ready,
  output logic [DATA_W-1:0] r_resp_data,
  output logic              init_done,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [SET_W-1:0]  RW0_addr,
  output logic [LANES-1:0]  RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);
  state_e           state;
  logic [SET_W-1:0] sweep_cnt;
  logic             in_init, in_idle, w_fire, r_fire;

  assign in_init = (state == ST_INIT);
  assign in_idle = (state == ST_IDLE);

  // Writes always win; a read also needs a free (or draining) response slot.
  assign w_req_ready = in_idle;
  assign r_req_ready = in_idle & ~w_req_valid & (~r_resp_valid | r_resp_ready);
  assign w_fire      = w_req_valid & w_req_ready;
  assign r_fire      = r_req_valid & r_req_ready;

  // Port mux: sweep writes zeros, otherwise requests pass straight through.
  assign RW0_en    = in_init | w_fire | r_fire;
  assign RW0_wmode = in_init | w_fire;
  assign RW0_addr  = in_init ? sweep_cnt : (w_fire ? w_req_set : r_req_set);
  assign RW0_wmask = in_init ? {LANES{1'b1}} : w_req_mask;
  assign RW0_wdata = in_init ? '0 : w_req_data;

  // Sweep every set once after reset, then serve requests until the next reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
      sweep_cnt <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (sweep_cnt == SET_W'(SETS - 1)) begin
            sweep_cnt <= '0;
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        ST_IDLE: init_done <= 1'b1;
        default: state <= ST_INIT;
      endcase
    end
  end

  sram_resp_hold #(.DATA_W(DATA_W)) u_hold (
    .clock      (clock),
    .reset_n    (reset_n),
    .issue      (r_fire),
    .rdata      (RW0_rdata),
    .resp_ready (r_resp_ready),
    .resp_valid (r_resp_valid),
    .resp_data  (r_resp_data)
  );
endmodule

// File: tb/tb_sram_sp_rw_ctrl.sv
// Bench for sram_sp_rw_ctrl: behavioural macro, directed vector table, reset
// corner sequences, and randomized traffic against a transaction-level model.
module tb_sram_sp_rw_ctrl;
  localparam int SETS = 512, SET_W = 9, LANES = 2, LW = 12, DATA_W = 24;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset_n, w_req_valid, w_req_ready, r_req_valid, r_req_ready;
  logic              r_resp_valid, r_resp_ready, init_done;
  logic [SET_W-1:0]  w_req_set, r_req_set, RW0_addr;
  logic [DATA_W-1:0] w_req_data, r_resp_data, RW0_wdata, RW0_rdata;
  logic [LANES-1:0]  w_req_mask, RW0_wmask;
  logic              RW0_en, RW0_wmode;

  sram_sp_rw_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .w_req_valid(w_req_valid), .w_req_ready(w_req_ready), .w_req_set(w_req_set),
    .w_req_data(w_req_data), .w_req_mask(w_req_mask),
    .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_set(r_req_set),
    .r_resp_valid(r_resp_valid), .r_resp_ready(r_resp_ready), .r_resp_data(r_resp_data),
    .init_done(init_done),
    .RW0_en(RW0_en), .RW0_wmode(RW0_wmode), .RW0_addr(RW0_addr),
    .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
  );

  // Macro model: masked write, 1-cycle read latency; scramble fills garbage.
  logic [DATA_W-1:0] mem [SETS];
  logic              scramble;
  always @(posedge clock) begin
    if (scramble) begin
      for (int i = 0; i < SETS; i++) mem[i] <= DATA_W'($urandom);
    end else if (RW0_en) begin
      if (RW0_wmode) begin
        for (int l = 0; l < LANES; l++)
          if (RW0_wmask[l]) mem[RW0_addr][l*LW +: LW] <= RW0_wdata[l*LW +: LW];
      end else begin
        RW0_rdata <= mem[RW0_addr];
      end
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    w_req_valid = 0; w_req_set = '0; w_req_data = '0; w_req_mask = '0;
    r_req_valid = 0; r_req_set = '0; r_resp_ready = 1;
  endtask

  // Expect n sweep cycles starting at set 0 with everything else blocked.
  task automatic sweep_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk($sformatf("sweep%0d", i),
          {RW0_en, RW0_wmode, RW0_wmask, w_req_ready, r_req_ready, init_done,
           r_resp_valid, RW0_addr},
          {1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 9'(i)});
      chk("sweep_wdata", RW0_wdata, 0);
      step();
    end
  endtask

  typedef struct {
    logic wv; logic [8:0] ws; logic [23:0] wd; logic [1:0] wm;
    logic rv; logic [8:0] rs; logic rr;
    logic ewr; logic err; logic evld; logic [23:0] edat;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic wv, logic [8:0] ws, logic [23:0] wd, logic [1:0] wm,
                              logic rv, logic [8:0] rs, logic rr,
                              logic err, logic evld, logic [23:0] edat);
    vec_t v;
    v.wv = wv; v.ws = ws; v.wd = wd; v.wm = wm; v.rv = rv; v.rs = rs; v.rr = rr;
    v.ewr = 1'b1; v.err = err; v.evld = evld; v.edat = edat;
    return v;
  endfunction

  logic [DATA_W-1:0] ref_mem [SETS];
  logic [DATA_W-1:0] q[$];
  logic              wv, rv, rr, ev, er;

  initial begin
    //             wv ws      wd         wm    rv rs      rr err vld data
    tbl.push_back(mk(0, 9'h000, 24'h0,      2'b00, 1, 9'h1FF, 1, 1, 0, 24'h0));
    tbl.push_back(mk(0, 9'h000, 24'h0,      2'b00, 1, 9'h000, 1, 1, 1, 24'h000000));
    tbl.push_back(mk(0, 9'h000, 24'h0,      2'b00, 0, 9'h000, 1, 1, 1, 24'h000000));
    tbl.push_back(mk(1, 9'h1A5, 24'hABC123, 2'b11, 0, 9'h000, 1, 0, 0, 24'h0));
    tbl.push_back(mk(0, 9'h000, 24'h0,      2'b00, 1, 9'h1A5, 1, 1, 0, 24'h0));
    tbl.push_back(mk(0, 9'h000, 24'h0,      2'b00, 0, 9'h000, 1, 1, 1, 24'hABC123));
    tbl.push_back(mk(1, 9'h1A5, 24'h555777, 2'b01, 0, 9'h000, 1, 0, 0, 24'h0));
    tbl.push_back(mk(0, 9'h000, 24'h0,      2'b00, 1, 9'h1A5, 1, 1, 0, 24'h0));
    tbl.push_back(mk(0, 9'h000, 24'h0,      2'b00, 0, 9'h000, 1, 1, 1, 24'hABC777));
    tbl.push_back(mk(1, 9'h010, 24'h123456, 2'b11, 1, 9'h010, 1, 0, 0, 24'h0));
    tbl.push_back(mk(0, 9'h000, 24'h0,      2'b00, 1, 9'h010, 1, 1, 0, 24'h0));
    tbl.push_back(mk(0, 9'h000, 24'h0,      2'b00, 0, 9'h000, 1, 1, 1, 24'h123456));
    tbl.push_back(mk(0, 9'h000, 24'h0,      2'b00, 1, 9'h1A5, 1, 1, 0, 24'h0));
    tbl.push_back(mk(1, 9'h1A5, 24'h000000, 2'b11, 0, 9'h000, 0, 0, 1, 24'hABC777));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 9'h000, 24'h0,    2'b00, 1, 9'h1A5, 0, 0, 1, 24'hABC777));
    tbl.push_back(mk(0, 9'h000, 24'h0,      2'b00, 1, 9'h1A5, 1, 1, 1, 24'hABC777));
    tbl.push_back(mk(0, 9'h000, 24'h0,      2'b00, 0, 9'h000, 1, 1, 1, 24'h000000));
    tbl.push_back(mk(0, 9'h000, 24'h0,      2'b00, 1, 9'h010, 1, 1, 0, 24'h0));
    tbl.push_back(mk(0, 9'h000, 24'h0,      2'b00, 1, 9'h1A5, 1, 1, 1, 24'h123456));
    tbl.push_back(mk(0, 9'h000, 24'h0,      2'b00, 0, 9'h000, 1, 1, 1, 24'h000000));
    tbl.push_back(mk(1, 9'h010, 24'hFFFFFF, 2'b00, 0, 9'h000, 1, 0, 0, 24'h0));
    tbl.push_back(mk(0, 9'h000, 24'h0,      2'b00, 1, 9'h010, 1, 1, 0, 24'h0));
    tbl.push_back(mk(0, 9'h000, 24'h0,      2'b00, 0, 9'h000, 1, 1, 1, 24'h123456));
    tbl.push_back(mk(0, 9'h000, 24'h0,      2'b00, 0, 9'h000, 1, 1, 0, 24'h0));

    // Reset with garbage in the array and requests held high during the sweep.
    idle_in();
    reset_n = 0; scramble = 1;
    step();
    scramble = 0;
    w_req_valid = 1; w_req_set = 9'h033; w_req_data = 24'hFFFFFF; w_req_mask = 2'b11;
    r_req_valid = 1;
    step();
    reset_n = 1;
    sweep_check(SETS);
    @(negedge clock);
    chk("init_done_rise", {init_done, w_req_ready}, 2'b11);
    step();

    // Directed vectors.
    foreach (tbl[k]) begin
      w_req_valid = tbl[k].wv; w_req_set = tbl[k].ws; w_req_data = tbl[k].wd;
      w_req_mask = tbl[k].wm; r_req_valid = tbl[k].rv; r_req_set = tbl[k].rs;
      r_resp_ready = tbl[k].rr;
      @(negedge clock);
      chk($sformatf("vec%0d_wrdy", k), w_req_ready, tbl[k].ewr);
      chk($sformatf("vec%0d_rrdy", k), r_req_ready, tbl[k].err);
      chk($sformatf("vec%0d_rvld", k), r_resp_valid, tbl[k].evld);
      if (tbl[k].evld) chk($sformatf("vec%0d_rdata", k), r_resp_data, tbl[k].edat);
      step();
    end

    // Reset while a response is pending, then again mid-sweep at set 100.
    idle_in();
    r_req_valid = 1; r_req_set = 9'h1A5; r_resp_ready = 0;
    @(negedge clock);
    chk("t6_rd_issue", r_req_ready, 1);
    step();
    r_req_valid = 0; reset_n = 0;
    @(negedge clock);
    chk("t6_pending", r_resp_valid, 1);
    step();
    reset_n = 1;
    sweep_check(100);
    @(negedge clock);
    chk("t6_cnt100", RW0_addr, 100);
    reset_n = 0;
    step();
    reset_n = 1;
    sweep_check(SETS);
    @(negedge clock);
    chk("t6_done", init_done, 1);
    step();

    // Randomized traffic against a transaction model (array is all zero now).
    for (int i = 0; i < SETS; i++) ref_mem[i] = '0;
    for (int c = 0; c < 600; c++) begin
      wv = ($urandom_range(0, 9) < 3);
      rv = ($urandom_range(0, 9) < 5);
      rr = ($urandom_range(0, 9) < 6);
      w_req_valid = wv; r_req_valid = rv; r_resp_ready = rr;
      w_req_set  = 9'($urandom_range(0, 15));
      r_req_set  = 9'($urandom_range(0, 15));
      w_req_data = DATA_W'($urandom);
      w_req_mask = 2'($urandom_range(0, 3));
      @(negedge clock);
      ev = (q.size() != 0);
      er = ~wv & (~ev | rr);
      chk("rnd_rvld", r_resp_valid, ev);
      if (ev) chk("rnd_rdata", r_resp_data, q[0]);
      chk("rnd_wrdy", w_req_ready, 1);
      chk("rnd_rrdy", r_req_ready, er);
      chk("rnd_en", RW0_en, wv | (er & rv));
      if (wv) chk("rnd_wcmd", {RW0_wmode, RW0_addr}, {1'b1, w_req_set});
      else if (er & rv) chk("rnd_rcmd", {RW0_wmode, RW0_addr}, {1'b0, r_req_set});
      if (ev && rr) void'(q.pop_front());
      if (wv)
        for (int l = 0; l < LANES; l++)
          if (w_req_mask[l]) ref_mem[w_req_set][l*LW +: LW] = w_req_data[l*LW +: LW];
      if (er && rv) q.push_back(ref_mem[r_req_set]);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
